croc_input_conditioner: RTL and testbench
=========================================

// Module: croc_input_conditioner
// PURPOSE
//  Multi-channel input conditioner, successor to the fixed 2-stage fetch-enable
//  synchronizer: per-channel N-stage sync, programmable debounce filter, edge
//  detection and sticky event flags with a combined interrupt. Sits between
//  GPIO/pad inputs and croc_domain/user_domain consumers (gpio_in_sync, irqs).
// PARAMETERS
//  NumCh      16    number of independent input channels (>=1)
//  SyncStages 2     synchronizer flops per channel (>=2)
//  DebounceW  8     width of debounce threshold/counters (>=1)
//  ResetValue 1'b0  reset value of sync chain and stable state, all channels
// PORTS
//  clk_i              in   1          single clock
//  rst_i              in   1          synchronous, active-high reset
//  in_i               in   NumCh      asynchronous raw inputs
//  debounce_cycles_i  in   DebounceW  threshold D, shared by all channels
//  edge_mode_i        in   2*NumCh    per ch [2c+1:2c]: 00 off,01 rise,10 fall,11 both
//  evt_clr_i          in   NumCh      per-channel pending clear (1-cycle pulse/level)
//  sync_o             out  NumCh      synchronized, unfiltered value
//  stable_o           out  NumCh      debounced value
//  evt_pend_o         out  NumCh      sticky edge-event flags
//  irq_o              out  1          OR of evt_pend_o
// BEHAVIOUR
//  Reset (rst_i=1 at edge): sync chain, sync_o, stable_o <= ResetValue; counters,
//   evt_pend_o, irq_o <= 0. Reset dominates all other inputs; mid-debounce reset
//   discards partial count; no event generated by reset or by leaving reset.
//  Sync: in_i -> sync_o after exactly SyncStages edges; no other logic on chain.
//  Debounce per channel, Deff = max(D,1):
//   - mismatch = (sync_o != stable_o).
//   - mismatch & cnt+1 >= Deff: stable_o <= sync_o, cnt <= 0.
//   - mismatch otherwise: cnt <= cnt+1 (cannot wrap: flip occurs first).
//   - no mismatch: cnt <= 0 (glitch shorter than Deff cycles rejected).
//   - stable_o flips on the Deff-th consecutive mismatch cycle; total latency
//     in_i change -> stable_o = SyncStages + Deff edges. D=0 behaves as D=1.
//   - D lowered mid-count: >= compare, flips on next mismatch cycle if cnt+1>=new D.
//  Edge detect: rise = stable 0->1, fall = 1->0, qualified by edge_mode_i
//   sampled in same cycle as the stable_o update; pend set one edge after flip.
//  Pending: set by qualified edge, cleared by evt_clr_i; simultaneous set and
//   clear -> set wins (event never lost). Mode change does not clear pending.
//  irq_o: registered-equivalent, = |evt_pend_o combinationally from flops; no
//   extra latency beyond evt_pend_o.
//  Channels fully independent; all outputs driven from flops only.
// TESTING (NumCh=4, SyncStages=2, DebounceW=8)
//  1 Reset: hold rst_i 3 cycles with in_i=4'hF -> sync_o/stable_o=0, pend=0,
//    irq_o=0; release -> sync_o=F after 2 edges, stable_o=F 2+Deff edges later.
//  2 Latency: D=0, ch0 0->1 -> sync_o[0] at edge 2, stable_o[0] at edge 3,
//    mode=01 -> evt_pend_o[0]=1 and irq_o=1 at edge 4.
//  3 Glitch: D=5, ch1 high for 4 cycles -> stable_o[1] stays 0, no event;
//    high for 5 cycles -> stable_o[1]=1 at edge 7.
//  4 Modes: ch2 mode=10 toggles 0->1->0 -> only fall sets pend; mode=11 both
//    edges set; mode=00 neither; evt_clr_i[2] pulse clears pend next edge.
//  5 Collision: evt_clr_i[3]=1 in same cycle pend[3] set -> pend[3]=1 persists;
//    clear again next cycle -> 0, irq_o=0 when all pend clear.
//  6 Reset mid-op: D=10, ch0 mismatch for 6 cycles, assert rst_i -> cnt lost,
//    stable_o=0; after release a full 10-cycle mismatch is needed to flip.

Source files
------------

// File: rtl/croc_input_conditioner.sv
// Multi-channel input conditioner. Each channel passes through an N-stage
// synchronizer, a debounce filter, an edge detector and a sticky event flag.
// A combined interrupt is asserted while any event flag is pending.

// Per-channel conditioning path: sync chain -> debounce -> edge -> pending.
module croc_input_conditioner_ch #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned DebounceW  = 8,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_i,
  input  logic [DebounceW-1:0] deff_i,
  input  logic [1:0]           edge_mode_i,
  input  logic                 evt_clr_i,
  output logic                 sync_o,
  output logic                 stable_o,
  output logic                 evt_pend_o
);

  logic [SyncStages-1:0] sync_q;
  logic [DebounceW-1:0]  cnt_q;
  logic                  stable_q;
  logic                  evt_q;
  logic                  pend_q;

  logic                  mismatch;
  logic [DebounceW:0]    cnt_inc;
  logic                  flip;
  logic                  qual_edge;

  assign sync_o     = sync_q[SyncStages-1];
  assign stable_o   = stable_q;
  assign evt_pend_o = pend_q;

  // One extra bit on the increment so the threshold compare never overflows.
  assign mismatch = sync_o != stable_q;
  assign cnt_inc  = {1'b0, cnt_q} + {{DebounceW{1'b0}}, 1'b1};
  assign flip     = mismatch && (cnt_inc >= {1'b0, deff_i});

  // The new stable value is sync_o itself, so a rise lands at 1 and a fall at 0.
  assign qual_edge = flip && ((sync_o && edge_mode_i[0]) || (!sync_o && edge_mode_i[1]));

  // Plain shift chain; nothing else may touch these flops (metastability).
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {SyncStages{ResetValue}};
    else       sync_q <= {sync_q[SyncStages-2:0], in_i};
  end

  // Debounce: count consecutive mismatch cycles, flip on the Deff-th one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= ResetValue;
      cnt_q    <= '0;
    end else if (flip) begin
      stable_q <= sync_o;
      cnt_q    <= '0;
    end else if (mismatch) begin
      cnt_q    <= cnt_inc[DebounceW-1:0];
    end else begin
      cnt_q    <= '0;
    end
  end

  // Registered qualified edge, so pending rises one edge after stable flips.
  always_ff @(posedge clk_i) begin
    if (rst_i) evt_q <= 1'b0;
    else       evt_q <= qual_edge;
  end

  // Sticky flag; a new event beats a simultaneous clear so none is lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= 1'b0;
    else       pend_q <= evt_q | (pend_q & ~evt_clr_i);
  end

endmodule

module croc_input_conditioner #(
  parameter int unsigned NumCh      = 16,
  parameter int unsigned SyncStages = 2,
  parameter int unsigned DebounceW  = 8,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumCh-1:0]     in_i,
  input  logic [DebounceW-1:0] debounce_cycles_i,
  input  logic [2*NumCh-1:0]   edge_mode_i,
  input  logic [NumCh-1:0]     evt_clr_i,
  output logic [NumCh-1:0]     sync_o,
  output logic [NumCh-1:0]     stable_o,
  output logic [NumCh-1:0]     evt_pend_o,
  output logic                 irq_o
);

  logic [DebounceW-1:0] deff;

  // A zero threshold behaves as one: flip on the first mismatch cycle.
  assign deff = (debounce_cycles_i == '0) ? DebounceW'(1) : debounce_cycles_i;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    croc_input_conditioner_ch #(
      .SyncStages (SyncStages),
      .DebounceW  (DebounceW),
      .ResetValue (ResetValue)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_i        (in_i[c]),
      .deff_i      (deff),
      .edge_mode_i (edge_mode_i[2*c+1:2*c]),
      .evt_clr_i   (evt_clr_i[c]),
      .sync_o      (sync_o[c]),
      .stable_o    (stable_o[c]),
      .evt_pend_o  (evt_pend_o[c])
    );
  end

  // OR of flop outputs only: same timing as evt_pend_o.
  assign irq_o = |evt_pend_o;

endmodule

// File: tb/tb_croc_input_conditioner.sv
// Bench for croc_input_conditioner: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the channel rules.
module tb_croc_input_conditioner;
  localparam int NCH = 4;
  localparam int SYNC = 2;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  in_r;
  logic [DW-1:0]   d_r;
  logic [2*NCH-1:0] mode_r;
  logic [NCH-1:0]  clr_r;
  logic [NCH-1:0]  sync_o, stable_o, evt_pend_o;
  logic            irq_o;

  int total = 0;
  int bad = 0;

  // Reference state
  logic [NCH-1:0] hist [SYNC];
  logic [NCH-1:0] m_sync, m_stable, m_evt, m_pend;
  int             run [NCH];

  croc_input_conditioner #(.NumCh(NCH), .SyncStages(SYNC), .DebounceW(DW), .ResetValue(1'b0)) dut (
    .clk_i(clk), .rst_i(rst), .in_i(in_r), .debounce_cycles_i(d_r),
    .edge_mode_i(mode_r), .evt_clr_i(clr_r),
    .sync_o(sync_o), .stable_o(stable_o), .evt_pend_o(evt_pend_o), .irq_o(irq_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model of one clock edge, using the inputs currently applied.
  task automatic model_step();
    int deff;
    logic [NCH-1:0] n_evt;
    if (rst) begin
      for (int k = 0; k < SYNC; k++) hist[k] = '0;
      m_sync = '0; m_stable = '0; m_evt = '0; m_pend = '0;
      for (int c = 0; c < NCH; c++) run[c] = 0;
      return;
    end
    deff = (d_r == 0) ? 1 : int'(d_r);
    n_evt = '0;
    for (int c = 0; c < NCH; c++) begin
      if (m_sync[c] != m_stable[c]) begin
        run[c]++;
        if (run[c] >= deff) begin
          m_stable[c] = m_sync[c];
          run[c] = 0;
          n_evt[c] = m_sync[c] ? mode_r[2*c] : mode_r[2*c+1];
        end
      end else run[c] = 0;
    end
    m_pend = m_evt | (m_pend & ~clr_r);
    m_evt = n_evt;
    for (int k = SYNC-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = in_r;
    m_sync = hist[SYNC-1];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("sync", sync_o, m_sync);
    chk("stable", stable_o, m_stable);
    chk("pend", evt_pend_o, m_pend);
    chk("irq", irq_o, |m_pend);
  endtask

  initial begin
    rst = 1'b1; in_r = '1; d_r = 8'd3; mode_r = '0; clr_r = '0;
    m_sync = '0; m_stable = '0; m_evt = '0; m_pend = '0;
    for (int k = 0; k < SYNC; k++) hist[k] = '0;
    for (int c = 0; c < NCH; c++) run[c] = 0;

    // 1 Reset with all inputs high, then release
    repeat (3) tick();
    chk("t1_rst_sync", sync_o, 0);
    chk("t1_rst_stable", stable_o, 0);
    chk("t1_rst_pend", evt_pend_o, 0);
    chk("t1_rst_irq", irq_o, 0);
    rst = 1'b0;
    tick(); chk("t1_sync_e1", sync_o, 0);
    tick(); chk("t1_sync_e2", sync_o, 4'hF);
    tick(); tick(); chk("t1_stable_e4", stable_o, 0);
    tick(); chk("t1_stable_e5", stable_o, 4'hF);

    // 2 Latency with D=0, rising edge on ch0
    rst = 1'b1; in_r = '0; tick(); rst = 1'b0;
    d_r = 8'd0; mode_r = 8'h01; in_r = 4'h1;
    tick(); chk("t2_sync_e1", sync_o[0], 0);
    tick(); chk("t2_sync_e2", sync_o[0], 1);
    tick(); chk("t2_stable_e3", stable_o[0], 1); chk("t2_pend_e3", evt_pend_o[0], 0);
    tick(); chk("t2_pend_e4", evt_pend_o[0], 1); chk("t2_irq_e4", irq_o, 1);

    // 3 Glitch rejection on ch1 with D=5
    d_r = 8'd5; mode_r[3:2] = 2'b11;
    in_r[1] = 1'b1; repeat (4) tick();
    in_r[1] = 1'b0; repeat (10) tick();
    chk("t3_glitch_stable", stable_o[1], 0);
    chk("t3_glitch_pend", evt_pend_o[1], 0);
    in_r[1] = 1'b1; repeat (5) tick();
    in_r[1] = 1'b0;
    tick(); chk("t3_stable_e6", stable_o[1], 0);
    tick(); chk("t3_stable_e7", stable_o[1], 1);
    repeat (10) tick();

    // 4 Edge modes on ch2, D=1
    d_r = 8'd1; mode_r[5:4] = 2'b10;
    in_r[2] = 1'b1; repeat (6) tick(); chk("t4_fall_only_rise", evt_pend_o[2], 0);
    in_r[2] = 1'b0; repeat (6) tick(); chk("t4_fall_only_fall", evt_pend_o[2], 1);
    clr_r[2] = 1'b1; tick(); clr_r[2] = 1'b0; chk("t4_clr", evt_pend_o[2], 0);
    mode_r[5:4] = 2'b11;
    in_r[2] = 1'b1; repeat (6) tick(); chk("t4_both_rise", evt_pend_o[2], 1);
    clr_r[2] = 1'b1; tick(); clr_r[2] = 1'b0;
    in_r[2] = 1'b0; repeat (6) tick(); chk("t4_both_fall", evt_pend_o[2], 1);
    clr_r[2] = 1'b1; tick(); clr_r[2] = 1'b0;
    mode_r[5:4] = 2'b00;
    in_r[2] = 1'b1; repeat (6) tick();
    in_r[2] = 1'b0; repeat (6) tick(); chk("t4_off", evt_pend_o[2], 0);

    // 5 Set/clear collision on ch3
    mode_r[7:6] = 2'b01; in_r[3] = 1'b1;
    repeat (3) tick();
    clr_r[3] = 1'b1; tick(); chk("t5_set_wins", evt_pend_o[3], 1);
    tick(); chk("t5_clr_again", evt_pend_o[3], 0);
    clr_r = 4'hF; tick(); clr_r = '0;
    chk("t5_irq_clear", irq_o, 0);

    // 6 Reset in the middle of a debounce count
    d_r = 8'd10; mode_r = '0; in_r = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    in_r[0] = 1'b1; repeat (8) tick();
    chk("t6_pre_rst", stable_o[0], 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_stable", stable_o[0], 0);
    repeat (11) tick(); chk("t6_e11", stable_o[0], 0);
    tick(); chk("t6_e12", stable_o[0], 1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(59) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(3) == 0) in_r[c] = ~in_r[c];
        clr_r[c] = ($urandom_range(7) == 0);
      end
      if ($urandom_range(39) == 0) d_r = DW'($urandom_range(4));
      if ($urandom_range(29) == 0) mode_r = (2*NCH)'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
